spram_access_arbiter: RTL and testbench
=======================================

Name: spram_access_arbiter

Overview:
- Front end for the 16 Kx16 single-port RAM wrapper, whose read and write share one address and one access per cycle.
- Merges an independent write stream and read-request stream into one RAM access per clock.
- Tracks the RAM's 1-cycle read latency and returns read data on a backpressured valid/ready stream.
- Sits between the rasterizer/framebuffer control logic and the RAM wrapper.

Parameters:
- ADDR_WIDTH, 14: word address width.
- DATA_WIDTH, 16: data word width.
- MASK_WIDTH, 4: write nibble-mask width.
- STARVE_LIMIT, 8: consecutive write grants allowed while a read waits (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- s_wr_valid  in  1  write request valid.
- s_wr_ready  out  1  write request accepted.
- s_wr_addr  in  ADDR_WIDTH  write address.
- s_wr_data  in  DATA_WIDTH  write data.
- s_wr_mask  in  MASK_WIDTH  write nibble enables.
- s_rd_valid  in  1  read request valid.
- s_rd_ready  out  1  read request accepted.
- s_rd_addr  in  ADDR_WIDTH  read address.
- m_rd_valid  out  1  read data valid.
- m_rd_ready  in  1  read data consumed.
- m_rd_data  out  DATA_WIDTH  read data.
- ram_writeData  out  DATA_WIDTH  to RAM writeData.
- ram_writeCs  out  1  to RAM writeCs.
- ram_write  out  1  to RAM write.
- ram_writeAddr  out  ADDR_WIDTH  to RAM writeAddr.
- ram_writeMask  out  MASK_WIDTH  to RAM writeMask.
- ram_readCs  out  1  to RAM readCs.
- ram_readAddr  out  ADDR_WIDTH  to RAM readAddr.
- ram_readData  in  DATA_WIDTH  from RAM readData.

Behaviour:
- Transfer rule: a transfer occurs when valid && ready on the same rising edge.
- Grant and RAM strobes:
  - grant_w = s_wr_valid && !force_rd.
  - grant_r = s_rd_valid && credit_ok && !grant_w.
  - Both are combinational.
  - s_wr_ready = grant_w; s_rd_ready = credit_ok && !grant_w.
  - s_rd_ready may be high while s_rd_valid is low.
- Mutual exclusion: at most one grant per cycle; grant_w && grant_r never both high.
- RAM drive (combinational):
  - ram_writeCs = ram_write = grant_w; ram_readCs = grant_r.
  - ram_writeMask = grant_w ? s_wr_mask : 0.
  - Addresses and data pass straight through.
- Credit accounting:
  - inflight: 1-bit register, set on a grant_r cycle.
  - rsp_buf: 2-entry response FIFO.
  - credit_ok = (inflight + occupancy - pop) < 2, where pop = m_rd_valid && m_rd_ready.
- Read latency:
  - Read accepted in cycle T; RAM drives ram_readData in T+1; arbiter captures it into rsp_buf at the end of T+1.
  - m_rd_valid is high from T+2.
  - Returned data is always the word at s_rd_addr at time T.
  - Response order equals request order.
- Throughput: with m_rd_ready held high, one read per clock is sustained.
- Stalled consumer: with m_rd_ready low, at most 2 reads are outstanding, then s_rd_ready drops.
- Buffer full: captured data is never lost.
  - Credits guarantee a free slot exists whenever inflight is set.
  - Push and pop in the same cycle on a full FIFO are legal; occupancy is unchanged.
- Same-address ordering: a write granted in cycle T is visible to a read granted in T+1 or later, because the RAM has a single port.
- Default priority: strict write priority (force_rd = 0).
- Reset (reset == 0 on a rising edge):
  - inflight = 0, rsp_buf empty, m_rd_valid = 0, starvation counter = 0.
  - s_wr_ready = s_rd_ready = 0 and all ram_* strobes 0 while reset is asserted.
  - A read in flight at reset is discarded; no response is ever produced for it.
- m_rd_data: undefined when m_rd_valid is 0; held stable while m_rd_valid && !m_rd_ready.

Optional Feature:
- Macro: SPRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter ($clog2(STARVE_LIMIT+1) bits) increments on each grant_w while s_rd_valid && credit_ok.
  - It clears on grant_r, or on any cycle where a read is not both requested and creditable.
  - force_rd = (count == STARVE_LIMIT) && s_rd_valid && credit_ok.
  - Result: after STARVE_LIMIT write grants, exactly one read is granted, then the count restarts at 0.
- Undefined: counter is absent; force_rd is tied to 0 (strict write priority).

Test Plan:
- Write 0xBEEF mask 4'hF to addr 0x0010, then read 0x0010 one cycle later → m_rd_valid at accept+2, m_rd_data = 0xBEEF.
- Write 0x1234 mask 4'hF, then write 0xABCD mask 4'b0100 to addr 5, then read addr 5 → 0x1B34.
- 16 back-to-back reads of addr 0..15 (preloaded with addr^0x5A5A), m_rd_ready = 1 → 16 consecutive valid beats in order, no bubbles after the first.
- m_rd_ready = 0 with s_rd_valid held high → exactly 2 reads accepted, s_rd_ready = 0; release ready → both returned in order, then acceptance resumes.
- s_wr_valid and s_rd_valid both held high for 40 cycles:
  - Without the macro: zero reads are granted.
  - With the macro and STARVE_LIMIT = 8: a read is granted every 9th cycle.
- Assert reset for 1 cycle while a read is in flight → m_rd_valid stays 0, no stale beat; the next read returns correct data at accept+2.

Source files
------------

// File: rtl/spram_access_arbiter.sv
// Single-port RAM front end: merges write and read-request streams into one access per clock.
// Optional SPRAM_ARB_STARVE_GUARD_EN forces one read after STARVE_LIMIT consecutive write grants.
module spram_access_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned MASK_WIDTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_wr_valid,
  output logic                  s_wr_ready,
  input  logic [ADDR_WIDTH-1:0] s_wr_addr,
  input  logic [DATA_WIDTH-1:0] s_wr_data,
  input  logic [MASK_WIDTH-1:0] s_wr_mask,
  input  logic                  s_rd_valid,
  output logic                  s_rd_ready,
  input  logic [ADDR_WIDTH-1:0] s_rd_addr,
  output logic                  m_rd_valid,
  input  logic                  m_rd_ready,
  output logic [DATA_WIDTH-1:0] m_rd_data,
  output logic [DATA_WIDTH-1:0] ram_writeData,
  output logic                  ram_writeCs,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_writeAddr,
  output logic [MASK_WIDTH-1:0] ram_writeMask,
  output logic                  ram_readCs,
  output logic [ADDR_WIDTH-1:0] ram_readAddr,
  input  logic [DATA_WIDTH-1:0] ram_readData
);

  logic                  force_rd;
  logic                  credit_ok;
  logic                  grant_w;
  logic                  grant_r;
  logic                  push;
  logic                  pop;
  logic [2:0]            used;
  logic                  inflight_q;
  logic [1:0]            count_q;
  logic                  wptr_q;
  logic                  rptr_q;
  logic [DATA_WIDTH-1:0] buf_q [2];

  assign m_rd_valid = (count_q != 2'd0);
  assign m_rd_data  = buf_q[rptr_q];
  assign pop        = m_rd_valid && m_rd_ready;
  assign push       = inflight_q;

  // A read slot is free if in-flight plus buffered words, less this cycle's pop, stays below 2.
  always_comb begin
    used      = 3'(inflight_q) + 3'(count_q);
    credit_ok = used < (3'd2 + 3'(pop));
  end

  // Reset gates every grant so nothing reaches the RAM while it is asserted.
  assign grant_w    = reset && s_wr_valid && !force_rd;
  assign grant_r    = reset && s_rd_valid && credit_ok && !grant_w;
  assign s_wr_ready = grant_w;
  assign s_rd_ready = reset && credit_ok && !grant_w;

  assign ram_writeCs   = grant_w;
  assign ram_write     = grant_w;
  assign ram_writeMask = grant_w ? s_wr_mask : '0;
  assign ram_writeData = s_wr_data;
  assign ram_writeAddr = s_wr_addr;
  assign ram_readCs    = grant_r;
  assign ram_readAddr  = s_rd_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      inflight_q <= grant_r;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) buf_q[wptr_q] <= ram_readData;
  end

`ifdef SPRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic            rd_waiting;
  logic [CntW-1:0] starve_q;

  assign rd_waiting = s_rd_valid && credit_ok;
  assign force_rd   = rd_waiting && (starve_q == CntW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (grant_r || !rd_waiting) begin
      starve_q <= '0;
    end else if (grant_w) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_rd            = 1'b0;
`endif

endmodule

// File: tb/tb_spram_access_arbiter.sv
// Randomised and directed bench for spram_access_arbiter with a behavioural RAM and a
// shadow-memory / expected-response-queue reference model.
module tb_spram_access_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_wr_valid, s_wr_ready;
  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_wr_data;
  logic [MW-1:0] s_wr_mask;
  logic          s_rd_valid, s_rd_ready;
  logic [AW-1:0] s_rd_addr;
  logic          m_rd_valid, m_rd_ready;
  logic [DW-1:0] m_rd_data;
  logic [DW-1:0] ram_writeData, ram_readData;
  logic          ram_writeCs, ram_write, ram_readCs;
  logic [AW-1:0] ram_writeAddr, ram_readAddr;
  logic [MW-1:0] ram_writeMask;

  spram_access_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .s_wr_valid   (s_wr_valid),
    .s_wr_ready   (s_wr_ready),
    .s_wr_addr    (s_wr_addr),
    .s_wr_data    (s_wr_data),
    .s_wr_mask    (s_wr_mask),
    .s_rd_valid   (s_rd_valid),
    .s_rd_ready   (s_rd_ready),
    .s_rd_addr    (s_rd_addr),
    .m_rd_valid   (m_rd_valid),
    .m_rd_ready   (m_rd_ready),
    .m_rd_data    (m_rd_data),
    .ram_writeData(ram_writeData),
    .ram_writeCs  (ram_writeCs),
    .ram_write    (ram_write),
    .ram_writeAddr(ram_writeAddr),
    .ram_writeMask(ram_writeMask),
    .ram_readCs   (ram_readCs),
    .ram_readAddr (ram_readAddr),
    .ram_readData (ram_readData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] mask);
    logic [DW-1:0] r;
    r = old;
    for (int n = 0; n < MW; n++) if (mask[n]) r[n*4 +: 4] = nw[n*4 +: 4];
    return r;
  endfunction

  // Behavioural single-port RAM with registered read.
  logic [DW-1:0] ram_mem [1 << AW];
  always @(posedge clk) begin
    if (ram_writeCs && ram_write)
      ram_mem[ram_writeAddr] <= merge(ram_mem[ram_writeAddr], ram_writeData, ram_writeMask);
    if (ram_readCs) ram_readData <= ram_mem[ram_readAddr];
  end

  // Reference model: shadow memory plus queue of words owed to the consumer.
  logic [DW-1:0] shadow [1 << AW];
  logic [DW-1:0] exp_q [$];
  logic          rst_seen   = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_data;

  always @(negedge clk) begin
    logic wr_hs, rd_hs;
    wr_hs = s_wr_valid && s_wr_ready;
    rd_hs = s_rd_valid && s_rd_ready;
    if (!reset) begin
      check_eq("rst_gating", {s_wr_ready, s_rd_ready, ram_writeCs, ram_write, ram_readCs,
                              ram_writeMask}, '0);
      exp_q.delete();
      rst_seen   = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (rst_seen) check_eq("post_rst_valid", m_rd_valid, 0);
      rst_seen = 1'b0;
`ifndef SPRAM_ARB_STARVE_GUARD_EN
      check_eq("wr_priority", s_wr_ready, s_wr_valid);
`endif
      check_eq("one_grant", wr_hs && rd_hs, 0);
      check_eq("ram_rd_cs", ram_readCs, rd_hs);
      check_eq("ram_wr_cs", {ram_writeCs, ram_write}, {wr_hs, wr_hs});
      check_eq("ram_mask", ram_writeMask, wr_hs ? s_wr_mask : '0);
      if (stall_prev) begin
        check_eq("stall_valid", m_rd_valid, 1);
        check_eq("stall_data", m_rd_data, held_data);
      end
      if (m_rd_valid && m_rd_ready) begin
        if (exp_q.size() == 0) check_eq("beat_expected", m_rd_valid, 0);
        else check_eq("rd_data", m_rd_data, exp_q.pop_front());
      end
      stall_prev = m_rd_valid && !m_rd_ready;
      held_data  = m_rd_data;
      if (rd_hs) exp_q.push_back(shadow[s_rd_addr]);
      if (wr_hs) shadow[s_wr_addr] = merge(shadow[s_wr_addr], s_wr_data, s_wr_mask);
      if (exp_q.size() > 2) check_eq("outstanding", exp_q.size(), 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_wr_valid = 1'b0;
    s_rd_valid = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    s_wr_valid = 1'b1;
    s_wr_addr  = a;
    s_wr_data  = d;
    s_wr_mask  = m;
    #1;
    check_eq("wr_accept", s_wr_ready, 1);
    step();
    s_wr_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!m_rd_valid && n < max) begin
      step();
      n++;
    end
    if (!m_rd_valid) check_eq("rd_timeout", m_rd_valid, 1);
  endtask

  task automatic drain();
    idle();
    m_rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check_eq("drained", exp_q.size(), 0);
  endtask

  int acc, nrd, nwr;

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      ram_mem[a] = '0;
      shadow[a]  = '0;
    end
    reset      = 1'b0;
    s_wr_valid = 1'b1;
    s_rd_valid = 1'b1;
    s_wr_addr  = 14'h0300;
    s_wr_data  = 16'hDEAD;
    s_wr_mask  = 4'hF;
    s_rd_addr  = '0;
    m_rd_ready = 1'b1;
    repeat (3) step();
    idle();
    reset = 1'b1;
    #1;
    check_eq("rst_m_valid", m_rd_valid, 0);
    check_eq("rst_rd_ready", s_rd_ready, 1);

    // Write then read one cycle later; data appears at accept+2.
    write(14'h0010, 16'hBEEF, 4'hF);
    s_rd_valid = 1'b1;
    s_rd_addr  = 14'h0010;
    #1;
    check_eq("t1_rd_accept", s_rd_ready, 1);
    step();
    idle();
    check_eq("t1_lat_early", m_rd_valid, 0);
    step();
    check_eq("t1_lat_valid", m_rd_valid, 1);
    check_eq("t1_data", m_rd_data, 16'hBEEF);
    step();

    // Nibble-masked write merge.
    write(14'd5, 16'h1234, 4'hF);
    write(14'd5, 16'hABCD, 4'b0100);
    s_rd_valid = 1'b1;
    s_rd_addr  = 14'd5;
    step();
    idle();
    wait_valid(5);
    check_eq("t2_merge", m_rd_data, 16'h1B34);
    step();

    // Back-to-back reads with no bubbles.
    for (int a = 0; a < 16; a++) write(14'(a), 16'(a) ^ 16'h5A5A, 4'hF);
    s_rd_valid = 1'b1;
    s_rd_addr  = '0;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (i < 16) check_eq("bb_ready", s_rd_ready, 1);
      step();
      if (i + 1 < 16) s_rd_addr = 14'(i + 1);
      else s_rd_valid = 1'b0;
      check_eq("bb_valid", m_rd_valid, (i >= 1 && i <= 16));
      if (i >= 1 && i <= 16) check_eq("bb_data", m_rd_data, 16'(i - 1) ^ 16'h5A5A);
    end

    // Stalled consumer: two reads outstanding, then backpressure.
    write(14'h0020, 16'h1111, 4'hF);
    write(14'h0021, 16'h2222, 4'hF);
    m_rd_ready = 1'b0;
    s_rd_valid = 1'b1;
    s_rd_addr  = 14'h0020;
    acc        = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (s_rd_ready) acc++;
      step();
      s_rd_addr = 14'h0020 + 14'(acc);
    end
    #1;
    check_eq("stall_accepts", acc, 2);
    check_eq("stall_rd_ready", s_rd_ready, 0);
    check_eq("stall_m_valid", m_rd_valid, 1);
    m_rd_ready = 1'b1;
    #1;
    check_eq("release_rd_ready", s_rd_ready, 1);
    step();
    s_rd_valid = 1'b0;
    drain();

    // Contention: both streams held valid.
    s_wr_valid = 1'b1;
    s_wr_addr  = 14'h0100;
    s_wr_mask  = 4'hF;
    s_rd_valid = 1'b1;
    s_rd_addr  = 14'h0010;
    nrd        = 0;
    nwr        = 0;
    for (int k = 0; k < 40; k++) begin
      s_wr_data = 16'($urandom);
      #1;
      if (s_rd_ready) nrd++;
      if (s_wr_ready) nwr++;
      step();
    end
`ifdef SPRAM_ARB_STARVE_GUARD_EN
    check_eq("contend_reads", nrd, 4);
`else
    check_eq("contend_reads", nrd, 0);
`endif
    check_eq("contend_writes", nwr, 40 - nrd);
    drain();

    // Reset while a read is in flight: no stale beat.
    s_rd_valid = 1'b1;
    s_rd_addr  = 14'h0010;
    step();
    reset      = 1'b0;
    s_wr_valid = 1'b1;
    s_wr_addr  = 14'h0010;
    s_wr_data  = 16'h0000;
    s_wr_mask  = 4'hF;
    step();
    reset = 1'b1;
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("rst_no_beat", m_rd_valid, 0);
      step();
    end
    s_rd_valid = 1'b1;
    step();
    idle();
    check_eq("rst_lat_early", m_rd_valid, 0);
    step();
    check_eq("rst_lat_valid", m_rd_valid, 1);
    check_eq("rst_data", m_rd_data, 16'hBEEF);
    step();

    // Random traffic over a small address window.
    for (int k = 0; k < 400; k++) begin
      s_wr_valid = 1'($urandom_range(0, 1));
      s_wr_addr  = 14'($urandom_range(0, 15));
      s_wr_data  = 16'($urandom);
      s_wr_mask  = 4'($urandom);
      s_rd_valid = ($urandom_range(0, 2) != 0);
      s_rd_addr  = 14'($urandom_range(0, 15));
      m_rd_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
